velocity_cell_rmw_ctrl: RTL

//  Read-modify-write sequencer for one per-cell velocity RAM (single port, {vz,vy,vx}, addr 0 = particle count).
//  On start: reads the count, streams velocities 1..count to the motion-update unit (valid/ready),

---
 rtl/velocity_cell_rmw_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/velocity_cell_rmw_ctrl.sv
// Read-modify-write sequencer for one per-cell velocity RAM: streams words 1..count out, writes updates back.
// Optional feature macro VEL_RMW_CHECKSUM_EN adds wb_checksum (XOR of all words written in the pass).
module velocity_cell_rmw_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_velocity,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_velocity,
  input  logic                  in_valid,
`ifdef VEL_RMW_CHECKSUM_EN
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] wb_checksum
`else
  output logic                  in_ready
`endif
);

  // Handshakes (out_* and in_*): a beat transfers on the clock edge where valid && ready are both high;
  // the valid side keeps its payload stable and valid asserted until that edge.

  localparam int FIFO_DEPTH = 2 + RD_LATENCY;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_CNT   = 3'd1;
  localparam logic [2:0] ST_WAIT_CNT = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]            state;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] pop_cnt;

  logic [RD_LATENCY-1:0] rd_pipe_vld;
  logic [ADDR_WIDTH-1:0] rd_pipe_id [RD_LATENCY];
  logic [OCC_W-1:0]      inflight;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_id   [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    fifo_wr_idx;
  logic [FIFO_AW-1:0]    fifo_rd_idx;
  logic [OCC_W-1:0]      occ;

  logic                  wr_accept;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;
  logic                  count_last;
  logic [ADDR_WIDTH-1:0] q_count;
  logic                  q_over;
  logic [ADDR_WIDTH-1:0] q_clamped;

  assign q_count    = mem_q[ADDR_WIDTH-1:0];
  assign q_over     = q_count > MAX_COUNT;
  assign q_clamped  = q_over ? MAX_COUNT : q_count;
  assign count_last = (wait_cnt == 2'(RD_LATENCY - 1));

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign push      = rd_pipe_vld[RD_LATENCY-1];

  // A write to id k needs k already popped, so it can never overtake its own read.
  assign in_ready  = (state == ST_STREAM) && (wr_ptr <= count) && (wr_ptr <= pop_cnt);
  assign wr_accept = in_valid && in_ready;
  // Reads only go out when the skid FIFO has a reserved slot for the returning word.
  assign rd_issue  = (state == ST_STREAM) && !wr_accept && (rd_ptr <= count) &&
                     ((occ + inflight) < OCC_W'(FIFO_DEPTH));

  assign out_velocity = out_valid ? fifo_data[fifo_rd_idx] : '0;
  assign out_id       = out_valid ? fifo_id[fifo_rd_idx]   : '0;

  always_comb begin
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (state == ST_RD_CNT) begin
      mem_rden = 1'b1;
    end else if (wr_accept) begin
      mem_wren    = 1'b1;
      mem_address = wr_ptr;
      mem_data    = in_velocity;
    end else if (rd_issue) begin
      mem_rden    = 1'b1;
      mem_address = rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      count     <= '0;
      count_err <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RD_CNT;
            count_err <= 1'b0;
            wait_cnt  <= '0;
            rd_ptr    <= ADDR_WIDTH'(1);
            wr_ptr    <= ADDR_WIDTH'(1);
            pop_cnt   <= '0;
          end
        end
        ST_RD_CNT: state <= ST_WAIT_CNT;
        ST_WAIT_CNT: begin
          if (count_last) begin
            count     <= q_clamped;
            count_err <= q_over;
            state     <= (q_clamped == '0) ? ST_DONE : ST_STREAM;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_STREAM: begin
          if (wr_accept && (wr_ptr == count)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (rd_issue)  rd_ptr  <= rd_ptr + 1'b1;
      if (wr_accept) wr_ptr  <= wr_ptr + 1'b1;
      if (pop)       pop_cnt <= pop_cnt + 1'b1;
    end
  end

  // Read-return tracking: one tag per pipeline stage so the returning q is paired with its id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe_id[i] <= '0;
      inflight    <= '0;
      occ         <= '0;
      fifo_wr_idx <= '0;
      fifo_rd_idx <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        rd_pipe_vld[i] <= rd_pipe_vld[i-1];
        rd_pipe_id[i]  <= rd_pipe_id[i-1];
      end
      rd_pipe_vld[0] <= rd_issue;
      rd_pipe_id[0]  <= rd_ptr;
      inflight <= inflight + OCC_W'(rd_issue) - OCC_W'(push);
      occ      <= occ + OCC_W'(push) - OCC_W'(pop);
      if (push)
        fifo_wr_idx <= (fifo_wr_idx == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : fifo_wr_idx + 1'b1;
      if (pop)
        fifo_rd_idx <= (fifo_rd_idx == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : fifo_rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr_idx] <= mem_q;
      fifo_id[fifo_wr_idx]   <= rd_pipe_id[RD_LATENCY-1];
    end
  end

`ifdef VEL_RMW_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_checksum <= '0;
    end else if ((state == ST_IDLE) && start) begin
      wb_checksum <= '0;
    end else if (wr_accept) begin
      wb_checksum <= wb_checksum ^ in_velocity;
    end
  end
`endif

endmodule
